lsu_mem_ctrl: RTL and testbench

- Load/store initiator that drives the word-only data-memory responder port (`mem_read`/`mem_write`/`address`/`write_data`/`read_data`/`mem_ready`) on behalf of the pipeline.
- Accepts byte/half/word load and store requests through a valid/ready handshake.
- Performs lane extraction and sign-extension on loads, and read-modify-write for sub-word stores.
- Returns one response per request, with error reporting for misaligned accesses and memory timeouts.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_align.sv | 41 ++++
 rtl/lsu_mem_ctrl.sv | 159 +++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, controller states
// and the access legality check.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        RMW_RD_REQ,
        RMW_RD_WAIT,
        WR_REQ,
        WR_WAIT,
        RESP
    } state_t;

    // True for an illegal size or an address not aligned to the access size.
    function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return lane[0];
            SZ_W:    return |lane;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane handling: extract/extend a loaded lane, or merge a store
// lane into the word read back from memory.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b          = rdata[{lane, 3'b000} +: 8];
        h          = rdata[{lane[1], 4'b0000} +: 16];
        load_data  = rdata;
        merge_data = wdata;
        case (size)
            SZ_B: begin
                load_data  = {{24{~uns & b[7]}}, b};
                merge_data = rdata;
                merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_H: begin
                load_data  = {{16{~uns & h[15]}}, h};
                merge_data = rdata;
                merge_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data  = rdata;
                merge_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for a word-only memory port: one request at a time,
// sub-word stores done as read-modify-write, misalignment and timeout errors.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int AW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] address,
    output logic [31:0] write_data,
    input  logic [31:0] read_data,
    input  logic        mem_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [1:0]    lane_q, lane_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_ready_q, req_ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_err_q, resp_err_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic [31:0]   address_q, address_d;
    logic [31:0]   write_data_q, write_data_d;
    logic [31:0]   load_data, merge_data;
    logic          unused_ok;

    assign unused_ok = ^req_addr[31:AW+2];

    // write_data_q carries the store data through the read phase so the merge
    // needs no separate copy of it.
    lsu_align u_align (
        .size       (size_q),
        .uns        (uns_q),
        .lane       (lane_q),
        .rdata      (read_data),
        .wdata      (write_data_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        uns_d        = uns_q;
        lane_d       = lane_q;
        cnt_d        = cnt_q;
        address_d    = address_q;
        write_data_d = write_data_q;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    size_d       = req_size;
                    uns_d        = req_unsigned;
                    lane_d       = req_addr[1:0];
                    address_d    = 32'(req_addr[AW+1:2]);
                    write_data_d = req_wdata;
                    if (is_bad_access(req_size, req_addr[1:0])) begin
                        state_d    = RESP;
                        resp_err_d = 1'b1;
                    end else if (!req_we)       state_d = RD_REQ;
                    else if (req_size == SZ_W)  state_d = WR_REQ;
                    else                        state_d = RMW_RD_REQ;
                end
            end
            RD_REQ:     begin cnt_d = '0; state_d = RD_WAIT;     end
            RMW_RD_REQ: begin cnt_d = '0; state_d = RMW_RD_WAIT; end
            WR_REQ:     begin cnt_d = '0; state_d = WR_WAIT;     end
            RD_WAIT, RMW_RD_WAIT, WR_WAIT: begin
                if (mem_ready) begin
                    if (state_q == RD_WAIT) begin
                        resp_rdata_d = load_data;
                        state_d      = RESP;
                    end else if (state_q == RMW_RD_WAIT) begin
                        write_data_d = merge_data;
                        state_d      = WR_REQ;
                    end else begin
                        state_d = RESP;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d    = RESP;
                    resp_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Handshake and strobes are registered from the next state.
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
        mem_read_d   = (state_d == RD_REQ) || (state_d == RD_WAIT) ||
                       (state_d == RMW_RD_REQ) || (state_d == RMW_RD_WAIT);
        mem_write_d  = (state_d == WR_REQ) || (state_d == WR_WAIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            size_q       <= '0;
            uns_q        <= 1'b0;
            lane_q       <= '0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            address_q    <= '0;
            write_data_q <= '0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            lane_q       <= lane_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign address    = address_q;
    assign write_data = write_data_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: word memory responder with selectable ready
// behaviour, directed scenarios and a randomized run against a memory model.
module tb_lsu_mem_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_read, mem_write, mem_ready;
    logic [31:0] resp_rdata, address, write_data, read_data;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.TIMEOUT(TIMEOUT), .AW(8)) dut (
        .clk(clk), .rst(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .write_data(write_data), .read_data(read_data),
        .mem_ready(mem_ready)
    );

    int checks = 0, failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder: mode 0 ready whenever requested, 1 random ready, 2 never ready.
    logic [1:0]  rmode = 2'd0;
    logic        rbit = 1'b0;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic        init_en = 1'b0, pl_en = 1'b0;
    logic [7:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;

    function automatic logic [31:0] pat(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    assign mem_ready = (mem_read || mem_write) && (rmode == 2'd0 || (rmode == 2'd1 && rbit));
    assign read_data = mem[address[7:0]];

    always @(negedge clk) rbit = ($urandom_range(3) != 0);

    always @(posedge clk) begin
        if (init_en) for (int i = 0; i < 256; i++) mem[i] <= pat(i);
        else if (pl_en) mem[pl_idx] <= pl_val;
        else if (mem_write && mem_ready) mem[address[7:0]] <= write_data;
    end

    int both_hi = 0, addr_hi = 0;
    always @(negedge clk) begin
        if (mem_read && mem_write) both_hi++;
        if (address[31:8] != 24'd0) addr_hi++;
    end

    // Memory model: expected result of one request, updating ref_mem on stores.
    function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic er);
        int idx, sh, sh16;
        logic [31:0] w, v;
        idx  = int'(a[9:2]);
        sh   = int'(a[1:0]) * 8;
        sh16 = a[1] ? 16 : 0;
        w    = ref_mem[idx];
        er   = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        rd   = '0;
        if (!er) begin
            if (!we) begin
                case (sz)
                    2'd0: begin v = (w >> sh) & 32'hFF;    rd = (!uns && v[7])  ? (v | 32'hFFFFFF00) : v; end
                    2'd1: begin v = (w >> sh16) & 32'hFFFF; rd = (!uns && v[15]) ? (v | 32'hFFFF0000) : v; end
                    default: rd = w;
                endcase
            end else begin
                case (sz)
                    2'd0: ref_mem[idx] = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
                    2'd1: ref_mem[idx] = (w & ~(32'hFFFF << sh16)) | ((wd & 32'hFFFF) << sh16);
                    default: ref_mem[idx] = wd;
                endcase
            end
        end
    endfunction

    logic [31:0] r_rd, r_waddr, r_wdata, r_raddr, m_rd;
    logic        r_er, r_srd, r_swr, m_er;
    int          r_lat, r_acc;

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd);
        int guard = 0;
        r_rd = '0; r_er = 1'b0; r_srd = 1'b0; r_swr = 1'b0;
        r_waddr = '0; r_wdata = '0; r_raddr = '0; r_lat = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        if (!req_ready) begin
            checks++; failures++;
            $display("FAIL req_ready_wait got=0 exp=1");
        end
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd; r_acc = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom_range(3)); req_we = 1'($urandom_range(1));
        while (r_lat < 60) begin
            @(negedge clk);
            r_lat++;
            if (mem_read)  begin r_srd = 1'b1; r_raddr = address; end
            if (mem_write) begin r_swr = 1'b1; r_waddr = address; r_wdata = write_data; end
            if (resp_valid) begin r_rd = resp_rdata; r_er = resp_err; break; end
        end
        if (!resp_valid) begin
            checks++; failures++;
            $display("FAIL resp_timeout got=no_resp exp=resp_valid");
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] v);
        @(negedge clk);
        pl_idx = 8'(idx); pl_val = v; pl_en = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[idx] = v;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
        checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin failures++; $display("FAIL rst_resp got=%b%b exp=00", resp_valid, resp_err); end
        checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin failures++; $display("FAIL rst_mem got=%b%b exp=00", mem_read, mem_write); end
        checks++; if (address !== 32'd0 || write_data !== 32'd0 || resp_rdata !== 32'd0) begin
            failures++; $display("FAIL rst_data got=%h/%h/%h exp=0", address, write_data, resp_rdata); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%b exp=1", req_ready); end
        init_en = 1'b1;
        @(negedge clk);
        init_en = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    endtask

    task automatic test_load_byte();
        set_word(3, 32'h8899AABB);
        do_req(1'b0, 2'd0, 1'b0, 32'h0D, 32'h0);
        checks++; if (r_rd !== 32'hFFFFFFAA || r_er !== 1'b0) begin failures++; $display("FAIL lb_signed got=%h/%b exp=ffffffaa/0", r_rd, r_er); end
        checks++; if (r_lat != 3 || r_raddr !== 32'd3) begin failures++; $display("FAIL lb_lat_addr got=%0d/%h exp=3/3", r_lat, r_raddr); end
        do_req(1'b0, 2'd0, 1'b1, 32'h0D, 32'h0);
        checks++; if (r_rd !== 32'h000000AA) begin failures++; $display("FAIL lb_unsigned got=%h exp=000000aa", r_rd); end
        do_req(1'b0, 2'd1, 1'b0, 32'h0E, 32'h0);
        checks++; if (r_rd !== 32'hFFFF8899) begin failures++; $display("FAIL lh_signed got=%h exp=ffff8899", r_rd); end
    endtask

    task automatic test_rmw();
        set_word(1, 32'h11223344);
        do_req(1'b1, 2'd0, 1'b0, 32'h05, 32'hFFFFFFAB);
        model(1'b1, 2'd0, 1'b0, 32'h05, 32'hFFFFFFAB, m_rd, m_er);
        checks++; if (!r_srd || !r_swr) begin failures++; $display("FAIL sb_phases got=rd%b/wr%b exp=rd1/wr1", r_srd, r_swr); end
        checks++; if (r_waddr !== 32'd1 || r_wdata !== 32'h1122AB44) begin failures++; $display("FAIL sb_write got=%h/%h exp=1/1122ab44", r_waddr, r_wdata); end
        checks++; if (r_lat != 5 || r_er !== 1'b0 || r_rd !== 32'd0) begin failures++; $display("FAIL sb_resp got=%0d/%b/%h exp=5/0/0", r_lat, r_er, r_rd); end
        do_req(1'b0, 2'd2, 1'b0, 32'h04, 32'h0);
        checks++; if (r_rd !== 32'h1122AB44) begin failures++; $display("FAIL sb_reload got=%h exp=1122ab44", r_rd); end
        do_req(1'b1, 2'd1, 1'b0, 32'h06, 32'h1234CAFE);
        model(1'b1, 2'd1, 1'b0, 32'h06, 32'h1234CAFE, m_rd, m_er);
        do_req(1'b0, 2'd2, 1'b0, 32'h04, 32'h0);
        checks++; if (r_rd !== 32'hCAFEAB44) begin failures++; $display("FAIL sh_reload got=%h exp=cafeab44", r_rd); end
    endtask

    task automatic test_word();
        do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF);
        model(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, m_rd, m_er);
        checks++; if (r_waddr !== 32'd8 || r_srd || r_lat != 3) begin failures++; $display("FAIL sw got=%h/rd%b/%0d exp=8/rd0/3", r_waddr, r_srd, r_lat); end
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        checks++; if (r_rd !== 32'hDEADBEEF || r_raddr !== 32'd8 || r_lat != 3) begin
            failures++; $display("FAIL lw got=%h/%h/%0d exp=deadbeef/8/3", r_rd, r_raddr, r_lat); end
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs [4] = '{32'h03, 32'h02, 32'h00, 32'h01};
        logic [1:0]  sizes [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
        logic        wes   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            do_req(wes[i], sizes[i], 1'b0, addrs[i], 32'hA5A5A5A5);
            checks++; if (r_er !== 1'b1 || r_lat != 1 || r_srd || r_swr || r_rd !== 32'd0) begin
                failures++; $display("FAIL misalign_%0d got=err%b/lat%0d/rd%b/wr%b/%h exp=err1/lat1/rd0/wr0/0", i, r_er, r_lat, r_srd, r_swr, r_rd); end
        end
    endtask

    task automatic test_timeout();
        rmode = 2'd2;
        do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        checks++; if (r_er !== 1'b1 || r_lat != TIMEOUT + 2 || r_rd !== 32'd0) begin
            failures++; $display("FAIL to_load got=err%b/lat%0d/%h exp=err1/lat%0d/0", r_er, r_lat, r_rd, TIMEOUT + 2); end
        do_req(1'b1, 2'd0, 1'b0, 32'h01, 32'h77);
        checks++; if (r_er !== 1'b1 || r_swr || r_lat != TIMEOUT + 2) begin
            failures++; $display("FAIL to_rmw got=err%b/wr%b/lat%0d exp=err1/wr0/lat%0d", r_er, r_swr, r_lat, TIMEOUT + 2); end
        rmode = 2'd0;
        do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        checks++; if (r_rd !== ref_mem[0] || r_er !== 1'b0) begin failures++; $display("FAIL to_unchanged got=%h exp=%h", r_rd, ref_mem[0]); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        rmode = 2'd2;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h09; req_wdata = 32'h5C;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || req_ready !== 1'b0 || address !== 32'd0 || write_data !== 32'd0) begin
            failures++; $display("FAIL mid_rst_outputs got=%b%b%b/%h/%h exp=000/0/0", mem_read, mem_write, req_ready, address, write_data); end
        @(negedge clk);
        rst_n = 1'b1;
        rmode = 2'd0;
        repeat (4) begin @(negedge clk); if (resp_valid) seen++; end
        checks++; if (seen != 0 || req_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_after got=resp%0d/rdy%b exp=resp0/rdy1", seen, req_ready); end
        do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
        checks++; if (r_rd !== ref_mem[2] || r_er !== 1'b0 || r_lat != 3) begin
            failures++; $display("FAIL mid_rst_load got=%h/%b/%0d exp=%h/0/3", r_rd, r_er, r_lat, ref_mem[2]); end
    endtask

    task automatic test_back_to_back();
        int a1;
        rmode = 2'd0;
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0); a1 = r_acc;
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL b2b_pulse_on got=%b exp=1", resp_valid); end
        do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
        checks++; if (r_acc - a1 != 4) begin failures++; $display("FAIL b2b_load got=%0d exp=4", r_acc - a1); end
        a1 = r_acc;
        do_req(1'b1, 2'd0, 1'b0, 32'h12, 32'h3C); model(1'b1, 2'd0, 1'b0, 32'h12, 32'h3C, m_rd, m_er);
        checks++; if (r_acc - a1 != 4) begin failures++; $display("FAIL b2b_store_after_load got=%0d exp=4", r_acc - a1); end
        a1 = r_acc;
        do_req(1'b0, 2'd2, 1'b0, 32'h03, 32'h0);
        checks++; if (r_acc - a1 != 6) begin failures++; $display("FAIL b2b_rmw got=%0d exp=6", r_acc - a1); end
        a1 = r_acc;
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        checks++; if (r_acc - a1 != 2 || r_rd !== ref_mem[4]) begin failures++; $display("FAIL b2b_err got=%0d/%h exp=2/%h", r_acc - a1, r_rd, ref_mem[4]); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_pulse_off got=%b exp=0", resp_valid); end
    endtask

    task automatic test_random();
        logic        we, uns;
        logic [1:0]  sz;
        logic [31:0] a, wd;
        int          bad = 0;
        rmode = 2'd1;
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(1)); sz = 2'($urandom_range(3)); uns = 1'($urandom_range(1));
            a = $urandom; wd = $urandom;
            if ($urandom_range(3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            model(we, sz, uns, a, wd, m_rd, m_er);
            do_req(we, sz, uns, a, wd);
            checks++;
            if (r_rd !== m_rd || r_er !== m_er) begin
                failures++; $display("FAIL rnd_%0d we%b sz%0d a=%h got=%h/%b exp=%h/%b", i, we, sz, a, r_rd, r_er, m_rd, m_er);
            end else if (m_er && (r_lat != 1 || r_srd || r_swr)) begin
                failures++; $display("FAIL rnd_err_%0d got=lat%0d/rd%b/wr%b exp=lat1/rd0/wr0", i, r_lat, r_srd, r_swr);
            end else if (!m_er && (r_swr !== we || r_lat < ((we && sz != 2'd2) ? 5 : 3))) begin
                failures++; $display("FAIL rnd_flow_%0d got=wr%b/lat%0d exp=wr%b", i, r_swr, r_lat, we);
            end
            if (!m_er && r_raddr !== 32'(a[9:2]) && r_waddr !== 32'(a[9:2])) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL rnd_address got=%0d exp=0", bad); end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_rmw();
        test_word();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        checks++; if (both_hi != 0) begin failures++; $display("FAIL rd_wr_overlap got=%0d exp=0", both_hi); end
        checks++; if (addr_hi != 0) begin failures++; $display("FAIL addr_upper got=%0d exp=0", addr_hi); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
